// File: rtl/hcode_shell_pkg.sv
// Shared types and constants for the hcode shell: channel count, word width,
// the output-arbiter state type and a constant-foldable ceil(log2) helper.
package hcode_shell_pkg;

  localparam int HC_NCH = 4;
  localparam int HC_DW  = 128;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Smallest r with 2**r >= v (returns 0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/hcode_rr_pick.sv
// Rotating-priority encoder: returns the first requester found when
// searching upward from last+1, wrapping modulo NCH (NCH is a power of two,
// so the wrap is plain truncation of the index).
module hcode_rr_pick
  import hcode_shell_pkg::*;
#(
  parameter  int NCH = HC_NCH,
  localparam int CW  = clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  last,
  output logic [CW-1:0]  pick,
  output logic           any
);

  logic [CW-1:0] idx;

  // Scan from the farthest offset down to the nearest so the nearest wins.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int i = NCH; i >= 1; i--) begin
      idx = last + CW'(i);
      if (req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hcode_out_arbiter.sv
// Merges NCH subshell ap_fifo write streams into one host-bound write port.
// One channel is granted at a time for up to MAX_BURST words; every word
// carries its source channel. A single output slot decouples the host FIFO
// full flag from the channel side, so ch_full never depends on ch_write.
module hcode_out_arbiter
  import hcode_shell_pkg::*;
#(
  parameter  int NCH       = HC_NCH,
  parameter  int DW        = HC_DW,
  parameter  int MAX_BURST = 16,
  localparam int CW        = clog2(NCH)
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [NCH*DW-1:0] ch_din,
  input  logic [NCH-1:0]    ch_write,
  output logic [NCH-1:0]    ch_full,
  output logic [DW-1:0]     out_din,
  output logic [CW-1:0]     out_chan,
  output logic              out_write,
  input  logic              out_full
);

  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] grant_q, grant_d;
  logic [CW-1:0] last_q, last_d;
  logic [7:0]    burst_q, burst_d;

  logic          vld_q;
  logic [DW-1:0] dat_q;
  logic [CW-1:0] chan_q;

  logic          slot_ready;
  logic          drain;
  logic          accept;
  logic [CW-1:0] pick;
  logic          any;

  hcode_rr_pick #(.NCH(NCH)) u_pick (
    .req  (ch_write),
    .last (last_q),
    .pick (pick),
    .any  (any)
  );

  assign slot_ready = !vld_q || !out_full;
  assign drain      = vld_q && !out_full;
  assign accept     = (state_q == GRANT) && ch_write[grant_q] && slot_ready;

  // Only the granted channel may see not-full, and only when the slot can take a word.
  always_comb begin
    ch_full = '1;
    if (state_q == GRANT) ch_full[grant_q] = !slot_ready;
  end

  // Arbitration next state: pick in IDLE, count and release in GRANT.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          grant_d = pick;
          burst_d = '0;
        end
      end
      GRANT: begin
        if (accept) burst_d = burst_q + 8'd1;
        // A stalled but still-writing channel keeps its grant.
        if (!ch_write[grant_q] || (accept && (burst_q + 8'd1 == BURST_LIM))) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration state registers; last starts at NCH-1 so channel 0 wins first.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= CW'(NCH - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  // Output slot: a load wins over a same-cycle drain, keeping full rate.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      vld_q  <= 1'b0;
      dat_q  <= '0;
      chan_q <= '0;
    end else if (accept) begin
      vld_q  <= 1'b1;
      dat_q  <= ch_din[int'(grant_q)*DW +: DW];
      chan_q <= grant_q;
    end else if (drain) begin
      vld_q  <= 1'b0;
    end
  end

  assign out_din   = dat_q;
  assign out_chan  = chan_q;
  assign out_write = vld_q;

endmodule

// File: tb/tb_hcode_out_arbiter.sv
// Bench for hcode_out_arbiter: reset values, a cycle table for a single stream
// and a backpressured stream, hand sequences for reset, early release,
// full-rate bursts and fairness, then a randomized run against per-channel
// word queues.
module tb_hcode_out_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   ch_write;
  logic [511:0] ch_din;
  logic [3:0]   ch_full;
  logic [127:0] out_din;
  logic [1:0]   out_chan;
  logic         out_write;
  logic         out_full;

  logic [3:0]   f_write;
  logic [511:0] f_din;
  logic [3:0]   f_full;
  logic [127:0] f_odin;
  logic [1:0]   f_ochan;
  logic         f_ow;
  logic         f_out_full;

  int vectors;
  int fails;
  int seq [4];
  logic         sb_on;
  logic [127:0] sbq [4][$];
  int           oq [$];
  logic [127:0] odq [$];

  typedef struct {
    logic [3:0] wr;
    logic       full;
    logic [3:0] e_chfull;
    logic       e_ow;
    int         e_chan;
    int         e_seq;
  } vec_t;
  vec_t tab [$];

  hcode_out_arbiter #(.NCH(4), .DW(128), .MAX_BURST(16)) u_dut (
    .ap_clk    (clk),
    .ap_rst    (rst),
    .ch_din    (ch_din),
    .ch_write  (ch_write),
    .ch_full   (ch_full),
    .out_din   (out_din),
    .out_chan  (out_chan),
    .out_write (out_write),
    .out_full  (out_full)
  );

  hcode_out_arbiter #(.NCH(4), .DW(128), .MAX_BURST(4)) u_dut4 (
    .ap_clk    (clk),
    .ap_rst    (rst),
    .ch_din    (f_din),
    .ch_write  (f_write),
    .ch_full   (f_full),
    .out_din   (f_odin),
    .out_chan  (f_ochan),
    .out_write (f_ow),
    .out_full  (f_out_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] mkw(input int c, input int s);
    return {32'(c), 32'(s), ~32'(s), 32'hC0DE_0000 + 32'(c)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] wr, input logic full, input logic [3:0] ef,
                     input logic eow, input int ec, input int es);
    vec_t v;
    v.wr = wr; v.full = full; v.e_chfull = ef; v.e_ow = eow; v.e_chan = ec; v.e_seq = es;
    tab.push_back(v);
  endtask

  // One clock: drive after the edge, observe transfers before the next edge.
  task automatic drive(input logic [3:0] wr, input logic full);
    @(posedge clk);
    #1;
    ch_write = wr;
    out_full = full;
    for (int i = 0; i < 4; i++) ch_din[i*128 +: 128] = mkw(i, seq[i]);
    @(negedge clk);
    if (out_write && !out_full) begin
      oq.push_back(int'(out_chan));
      odq.push_back(out_din);
    end
    if (sb_on) begin
      chk("one_grant", 128'($countones(~ch_full) <= 1), 128'(1));
      if (out_write && !out_full) begin
        if (sbq[out_chan].size() == 0) chk("rand_spurious", 128'(out_chan), 128'(4));
        else chk("rand_word", out_din, sbq[out_chan].pop_front());
      end
      for (int i = 0; i < 4; i++)
        if (ch_write[i] && !ch_full[i]) sbq[i].push_back(ch_din[i*128 +: 128]);
    end
    for (int i = 0; i < 4; i++)
      if (ch_write[i] && !ch_full[i]) seq[i]++;
  endtask

  initial begin
    int a0, a3, s1, cur_run, max_run, idx, n;
    logic started, exp_ow;

    vectors = 0; fails = 0; sb_on = 1'b0;
    for (int i = 0; i < 4; i++) seq[i] = 0;
    ch_write = '0; ch_din = '0; out_full = 1'b0;
    f_write = '0; f_out_full = 1'b0;
    for (int i = 0; i < 4; i++) f_din[i*128 +: 128] = mkw(i, 0);
    rst = 1'b1;

    // Reset values
    #3;
    chk("rst_ch_full", ch_full, 4'b1111);
    chk("rst_out_write", out_write, 0);
    chk("rst_out_din", out_din, 0);
    chk("rst_out_chan", out_chan, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single stream on ch2, five words
    add(4'b0100, 0, 4'b1111, 0, 0, 0);
    add(4'b0100, 0, 4'b1011, 0, 0, 0);
    add(4'b0100, 0, 4'b1011, 1, 2, 0);
    add(4'b0100, 0, 4'b1011, 1, 2, 1);
    add(4'b0100, 0, 4'b1011, 1, 2, 2);
    add(4'b0100, 0, 4'b1011, 1, 2, 3);
    add(4'b0000, 0, 4'b1011, 1, 2, 4);
    add(4'b0000, 0, 4'b1111, 0, 0, 0);
    // ch1 streaming with a three-cycle host stall
    add(4'b0010, 0, 4'b1111, 0, 0, 0);
    add(4'b0010, 0, 4'b1101, 0, 0, 0);
    add(4'b0010, 0, 4'b1101, 1, 1, 0);
    add(4'b0010, 1, 4'b1111, 1, 1, 1);
    add(4'b0010, 1, 4'b1111, 1, 1, 1);
    add(4'b0010, 1, 4'b1111, 1, 1, 1);
    add(4'b0010, 0, 4'b1101, 1, 1, 1);
    add(4'b0010, 0, 4'b1101, 1, 1, 2);
    add(4'b0000, 0, 4'b1101, 1, 1, 3);
    add(4'b0000, 0, 4'b1111, 0, 0, 0);

    foreach (tab[k]) begin
      drive(tab[k].wr, tab[k].full);
      chk($sformatf("tab%0d_ch_full", k), ch_full, tab[k].e_chfull);
      chk($sformatf("tab%0d_out_write", k), out_write, tab[k].e_ow);
      if (tab[k].e_ow) begin
        chk($sformatf("tab%0d_out_chan", k), out_chan, 128'(tab[k].e_chan));
        chk($sformatf("tab%0d_out_din", k), out_din, mkw(tab[k].e_chan, tab[k].e_seq));
      end
    end

    // Reset mid-burst with the slot holding a word
    drive(4'b0100, 0);
    drive(4'b0100, 0);
    drive(4'b0100, 0);
    chk("mid_pre_out_write", out_write, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_write", out_write, 0);
    chk("mid_rst_ch_full", ch_full, 4'b1111);
    chk("mid_rst_out_din", out_din, 0);
    drive(4'b0000, 0);
    chk("mid_rst_hold_ch_full", ch_full, 4'b1111);
    rst = 1'b0;

    // Early release: ch0 first after reset, drops after two words, ch3 next, then ch0
    oq.delete();
    a0 = seq[0];
    a3 = seq[3];
    for (n = 0; n < 20 && seq[0] - a0 < 2; n++) drive(4'b1001, 0);
    drive(4'b1000, 0);
    for (n = 0; n < 20 && seq[3] - a3 < 2; n++) drive(4'b1001, 0);
    for (n = 0; n < 8; n++) drive(4'b0001, 0);
    for (n = 0; n < 3; n++) drive(4'b0000, 0);
    chk("early_count", 128'(oq.size() >= 5), 128'(1));
    if (oq.size() >= 5) begin
      chk("early_w0", oq[0], 0);
      chk("early_w1", oq[1], 0);
      chk("early_w2", oq[2], 3);
      chk("early_w3", oq[3], 3);
      chk("early_w4", oq[4], 0);
    end

    // Sixteen words from ch1 at full rate
    odq.delete();
    s1 = seq[1];
    cur_run = 0;
    max_run = 0;
    for (n = 0; n < 40; n++) begin
      drive((seq[1] - s1 < 16) ? 4'b0010 : 4'b0000, 0);
      if (out_write) cur_run++;
      else begin
        if (cur_run > max_run) max_run = cur_run;
        cur_run = 0;
      end
    end
    if (cur_run > max_run) max_run = cur_run;
    chk("full_rate_run", max_run, 16);
    chk("full_rate_words", odq.size(), 16);
    for (int k = 0; k < odq.size() && k < 16; k++)
      chk($sformatf("full_rate_w%0d", k), odq[k], mkw(1, s1 + k));

    // Fairness on the MAX_BURST=4 instance
    @(posedge clk);
    #1;
    f_write = 4'hF;
    started = 1'b0;
    idx = 0;
    for (n = 0; n < 40 && idx < 25; n++) begin
      @(negedge clk);
      if (!started && f_ow) begin
        started = 1'b1;
        chk("fair_latency", n, 2);
      end
      if (started) begin
        exp_ow = (idx % 5) != 4;
        chk($sformatf("fair_write%0d", idx), f_ow, exp_ow);
        if (exp_ow) chk($sformatf("fair_chan%0d", idx), f_ochan, 128'((idx / 5) % 4));
        idx++;
      end
    end
    if (idx < 25) chk("fair_timeout", idx, 25);
    @(posedge clk);
    #1;
    f_write = '0;

    // Randomized traffic against per-channel word queues
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) sbq[i].delete();
    sb_on = 1'b1;
    for (n = 0; n < 3000; n++) begin
      logic [3:0] wr;
      for (int i = 0; i < 4; i++) wr[i] = ($urandom_range(0, 99) < 60);
      drive(wr, $urandom_range(0, 99) < 30);
    end
    for (n = 0; n < 40; n++) drive(4'b0000, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rand_left%0d", i), sbq[i].size(), 0);
    sb_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/hcode_out_arbiter.md
# hcode_out_arbiter

Round-robin arbiter that merges the four subshells' 128-bit ap_fifo output streams (`out_r_din`/`out_r_write`/`out_r_full`) into the single host-bound FIFO write port. It sits between the four `hcode_subshell_N` instances and the host write FIFO. It grants one channel at a time for a bounded burst and tags every word with its source channel. It presents a standard ap_fifo write side to each subshell and to the host FIFO.

## Interface
Parameters:
- `NCH`, 4, number of subshell channels (power of two)
- `DW`, 128, data width per word
- `MAX_BURST`, 16, maximum words accepted per grant (1..255)

Ports:
- `ap_clk`  in  1  single clock for all logic
- `ap_rst`  in  1  asynchronous, active-high reset
- `ch_din`  in  NCH*DW  channel i data at bits [i*DW +: DW]
- `ch_write`  in  NCH  channel i write strobe
- `ch_full`  out  NCH  full flag back to channel i
- `out_din`  out  DW  merged data to host FIFO
- `out_chan`  out  log2(NCH)  source channel of `out_din`
- `out_write`  out  1  merged write strobe
- `out_full`  in  1  host FIFO full

## Operation
- ap_fifo rule on every port: a word transfers in a cycle where write=1 and full=0.
- Output slot: one register holding `out_din`, `out_chan` and a valid bit; `out_write` = valid.
  - Slot drains when valid & !`out_full`.
  - `slot_ready` = !valid | !`out_full` (combinational).
- States: IDLE, GRANT. Registers: `grant` (log2 NCH), `last` (log2 NCH), `burst_cnt` (8 bit).
- IDLE
  - All `ch_full` = 1.
  - If any `ch_write` is high, pick the first requester searching from `last`+1 modulo NCH.
  - Next cycle: GRANT, `grant` = pick, `burst_cnt` = 0.
- GRANT
  - `ch_full[grant]` = !`slot_ready`; all other `ch_full` = 1.
  - Accept = `ch_write[grant]` & `slot_ready`. On accept, the slot loads `ch_din[grant]` and `out_chan` = `grant`, and `burst_cnt` increments.
- Release from GRANT to IDLE, with `last` = `grant`, when either:
  - an accept takes `burst_cnt` to MAX_BURST, or
  - `ch_write[grant]` = 0 in that cycle.
- `ch_write[grant]` = 1 while stalled by `out_full` is not idle and does not release.
- A slot load and a slot drain in the same cycle are both allowed: the slot stays valid with the new word.

## Timing
- Reset values:
  - `ch_full` = all ones; `out_write` = 0; `out_din` = 0; `out_chan` = 0.
  - State = IDLE; `last` = NCH-1, so channel 0 has first priority; `burst_cnt` = 0.
- Arbitration costs one bubble cycle: request seen in IDLE at cycle t, first accept possible at t+1.
- Data latency: accepted at cycle t, `out_write`=1 with the data at t+1.
- Sustained throughput within a burst is one word per cycle while `out_full` = 0. Per grant this gives MAX_BURST words in MAX_BURST+1 cycles.
- `out_full` reaches `ch_full[grant]` combinationally. There is no combinational path from `ch_write` to `ch_full`.
- Asserting `ap_rst` mid-burst immediately clears the slot valid bit; the held word is discarded. All `ch_full` go to 1 asynchronously.
- Word order is preserved within a channel. Interleaving between channels happens only at burst boundaries.

## Structure
- Shared package `hcode_shell_pkg`:
  - state enum `arb_state_t` {IDLE, GRANT};
  - constants `HC_NCH`=4, `HC_DW`=128;
  - function `clog2`.
- Sub-module `hcode_rr_pick`: combinational rotating-priority encoder. Inputs: req[NCH] and last. Outputs: pick and any.
- Everything else stays in `hcode_out_arbiter`.

## Test plan
- Single stream: only ch2 writes 5 words, `out_full`=0.
  - Expect 5 writes with `out_chan`=2, in order.
  - First `out_write` 2 cycles after the first `ch_write`.
  - Release after the 5th word.
- Fairness: all four channels write continuously, MAX_BURST=4, `out_full`=0.
  - Expect `out_chan` sequence 0,0,0,0,1,1,1,1,2,…,3,0, with one bubble between bursts.
- Backpressure: ch1 streaming, `out_full` high for 3 cycles mid-burst.
  - `ch_full[1]`=1 in those cycles and no word is lost or duplicated.
  - The grant does not release during the stall.
- Early release: ch0 drops `ch_write` after 2 words while ch3 is requesting.
  - Next grant goes to ch3; ch0 regains the grant only after ch3.
- Same-cycle load/drain at full rate: 16 consecutive words from ch1 emerge back-to-back, with `out_write` held high 16 cycles.
- Reset mid-burst: assert `ap_rst` with the slot valid.
  - `out_write`=0 and all `ch_full`=1 immediately.
  - After release, ch0 is granted first.
